adc_serial_rx: RTL and testbench

// - Downstream receiver for the SAR ADC controller's serial output stream.
// - Samples SerialOutput while DataMark is high, MSB first, one bit per clk, into DATA_W-bit words.
// - Buffers completed words in a FWFT FIFO, drained over a valid/ready interface.
// - Reports framing errors (short/long frames) and FIFO overflow to the system/debug block.

---
 rtl/adc_serial_rx.sv | 142 ++++++++++++++
 tb/tb_adc_serial_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_rx.sv
// Receiver for the SAR ADC serial stream: assembles MSB-first frames into words and buffers them in a FWFT FIFO.
// Optional serial/parallel cross-check of each frame against B is enabled by defining ADC_XCHECK_EN.
module adc_serial_rx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              SerialOutput,
  input  logic              DataMark,
  input  logic              LoadReg,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  level,
  output logic              err_frame,
  output logic              overflow,
  output logic              err_xcheck
);

  localparam int AW   = CNT_W - 1;
  localparam int BC_W = $clog2(DATA_W + 1);

  // Handshake: a word leaves the FIFO on a rising edge where dout_valid && dout_ready;
  // dout holds the head whenever dout_valid is high and reads 0 otherwise.

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, LONG} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg;
  logic [BC_W-1:0]   bcnt;
  logic              shift_en, frame_bad, push;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  wr_ptr, rd_ptr;
  logic              full, pop, wr_en;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    shift_en  = 1'b0;
    frame_bad = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (DataMark) begin
          shift_en = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (DataMark) begin
          shift_en = 1'b1;
          if (bcnt == BC_W'(DATA_W - 1)) state_nx = DONE;
        end else begin
          frame_bad = 1'b1;
          state_nx  = IDLE;
        end
      end
      DONE: begin
        // The word is complete; any bit still marked here makes the frame long.
        push     = 1'b1;
        state_nx = DataMark ? LONG : IDLE;
      end
      LONG: begin
        if (!DataMark) begin
          frame_bad = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shreg <= '0;
      bcnt  <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[DATA_W-2:0], SerialOutput};
      bcnt  <= (state == IDLE) ? BC_W'(1) : bcnt + BC_W'(1);
    end
  end

  // Occupancy from the extra pointer bit distinguishes full from empty.
  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == CNT_W'(DEPTH));
  assign dout_valid = (level != '0);
  assign pop        = dout_valid && dout_ready;
  assign wr_en      = push && (!full || pop);
  assign dout       = dout_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop)   rd_ptr <= rd_ptr + CNT_W'(1);
      if (push && full && !pop) overflow <= 1'b1;
      err_frame <= frame_bad;
    end
  end

`ifdef ADC_XCHECK_EN
  logic [DATA_W-1:0] ref_word;
  logic              xcheck_q;

  // A frame with no fresh LoadReg compares against the last captured result.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ref_word <= '0;
      xcheck_q <= 1'b0;
    end else begin
      if (LoadReg) ref_word <= B;
      xcheck_q <= push && (shreg != ref_word);
    end
  end

  assign err_xcheck = xcheck_q;
`else
  logic unused_xcheck;
  assign unused_xcheck = ^{B, LoadReg};
  assign err_xcheck    = 1'b0;
`endif

endmodule

// File: tb/tb_adc_serial_rx.sv
// Directed bench for adc_serial_rx: a frame table plus hand-written multi-cycle sequences.
module tb_adc_serial_rx;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       SerialOutput = 1'b0;
  logic       DataMark = 1'b0;
  logic       LoadReg = 1'b0;
  logic [7:0] B = 8'h00;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic [2:0] level;
  logic       err_frame;
  logic       overflow;
  logic       err_xcheck;

  int n_pass = 0;
  int n_total = 0;
  int err_cnt = 0;
  int xchk_cnt = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] pat;
    int          len;
    bit          exp_push;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  adc_serial_rx #(.DATA_W(8), .DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .clr(clr), .SerialOutput(SerialOutput), .DataMark(DataMark),
    .LoadReg(LoadReg), .B(B), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .level(level), .err_frame(err_frame),
    .overflow(overflow), .err_xcheck(err_xcheck)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_frame) err_cnt++;
    if (err_xcheck) xchk_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1; DataMark = 1'b0; SerialOutput = 1'b0; dout_ready = 1'b0; LoadReg = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Drives pat MSB first for len cycles, then drops DataMark and sets dout_ready.
  task automatic run_frame(input logic [15:0] pat, input int len, input logic rdy_end);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      DataMark = 1'b1;
      SerialOutput = pat[15-i];
    end
    @(negedge clk);
    DataMark = 1'b0;
    SerialOutput = 1'b0;
    dout_ready = rdy_end;
  endtask

  task automatic drain(input string name);
    dout_ready = 1'b0;
    for (int k = 0; k < 16 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      chk({name, "_valid"}, dout_valid, 1);
      chk({name, "_dout"}, dout, exp_q.pop_front());
      dout_ready = 1'b1;
    end
    chk({name, "_left"}, exp_q.size(), 0);
    @(negedge clk);
    dout_ready = 1'b0;
    chk({name, "_empty_level"}, level, 0);
    chk({name, "_empty_valid"}, dout_valid, 0);
    chk({name, "_empty_dout"}, dout, 0);
  endtask

  initial begin
    int e0;
    int lvl;

    vecs[0] = '{16'hA500, 8,  1'b1, 1'b0};
    vecs[1] = '{16'h5A00, 5,  1'b0, 1'b1};
    vecs[2] = '{16'hC3FF, 10, 1'b1, 1'b1};
    vecs[3] = '{16'h0000, 8,  1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 3,  1'b0, 1'b1};
    vecs[5] = '{16'hFF00, 8,  1'b1, 1'b0};

    // Reset state after a clr pulse and 10 idle cycles
    pulse_clr();
    repeat (10) @(negedge clk);
    chk("rst_valid", dout_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_dout", dout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_err_frame", err_frame, 0);
    chk("rst_err_xcheck", err_xcheck, 0);

    // Single frame A5 with ready held: valid for exactly one cycle
    run_frame(16'hA500, 8, 1'b1);
    @(negedge clk);
    chk("a5_valid", dout_valid, 1);
    chk("a5_dout", dout, 8'hA5);
    chk("a5_level", level, 1);
    @(negedge clk);
    dout_ready = 1'b0;
    chk("a5_gone_valid", dout_valid, 0);
    chk("a5_gone_level", level, 0);

    // Frame table: good, short, long and tiny frames with ready low
    pulse_clr();
    lvl = 0;
    for (int v = 0; v < 6; v++) begin
      e0 = err_cnt;
      run_frame(vecs[v].pat, vecs[v].len, 1'b0);
      repeat (3) @(negedge clk);
      if (vecs[v].exp_push) begin
        exp_q.push_back(vecs[v].pat[15:8]);
        lvl++;
      end
      chk($sformatf("tbl%0d_err", v), err_cnt - e0, vecs[v].exp_err ? 1 : 0);
      chk($sformatf("tbl%0d_level", v), level, lvl);
    end
    chk("tbl_overflow", overflow, 0);
    drain("tbl_drain");

    // Long frame: err_frame only after DataMark falls, word already pushed
    e0 = err_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      DataMark = 1'b1;
      SerialOutput = (i < 8) ? 1'(8'h69 >> (7 - i)) : 1'b1;
    end
    chk("long_level_before_fall", level, 1);
    chk("long_dout_before_fall", dout, 8'h69);
    chk("long_err_before_fall", err_cnt - e0, 0);
    @(negedge clk);
    DataMark = 1'b0;
    @(negedge clk);
    chk("long_err_pulse", err_frame, 1);
    @(negedge clk);
    chk("long_err_clear", err_frame, 0);
    chk("long_err_count", err_cnt - e0, 1);
    exp_q.push_back(8'h69);
    drain("long_drain");

    // Five frames into a 4-deep FIFO: last dropped, overflow sticky
    pulse_clr();
    for (int k = 1; k <= 5; k++) run_frame({8'(k), 8'h00}, 8, 1'b0);
    repeat (2) @(negedge clk);
    chk("ovf_level", level, 4);
    chk("ovf_flag", overflow, 1);
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    drain("ovf_drain");
    chk("ovf_sticky", overflow, 1);

    // Full FIFO, push and pop on the same edge: no overflow
    pulse_clr();
    run_frame(16'h1100, 8, 1'b0);
    run_frame(16'h2200, 8, 1'b0);
    run_frame(16'h3300, 8, 1'b0);
    run_frame(16'h4400, 8, 1'b0);
    run_frame(16'h5500, 8, 1'b1);
    @(negedge clk);
    dout_ready = 1'b0;
    chk("fullpp_level", level, 4);
    chk("fullpp_overflow", overflow, 0);
    chk("fullpp_dout", dout, 8'h22);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
    drain("fullpp_drain");

    // Level 1, push and pop on the same edge: new word becomes head
    run_frame(16'h6600, 8, 1'b0);
    @(negedge clk);
    run_frame(16'h7700, 8, 1'b1);
    @(negedge clk);
    dout_ready = 1'b0;
    chk("lvl1pp_level", level, 1);
    chk("lvl1pp_dout", dout, 8'h77);
    exp_q.push_back(8'h77);
    drain("lvl1pp_drain");

    // clr in the middle of a frame: partial word lost, next frame clean
    e0 = err_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      DataMark = 1'b1;
      SerialOutput = 1'b1;
    end
    pulse_clr();
    run_frame(16'h9600, 8, 1'b0);
    repeat (2) @(negedge clk);
    chk("midclr_level", level, 1);
    chk("midclr_dout", dout, 8'h96);
    chk("midclr_err", err_cnt - e0, 0);
    exp_q.push_back(8'h96);
    drain("midclr_drain");

`ifdef ADC_XCHECK_EN
    // Cross-check against the parallel result
    pulse_clr();
    e0 = xchk_cnt;
    @(negedge clk);
    B = 8'h3C; LoadReg = 1'b1;
    @(negedge clk);
    LoadReg = 1'b0; B = 8'h00;
    run_frame(16'h3C00, 8, 1'b0);
    repeat (2) @(negedge clk);
    chk("xchk_match", xchk_cnt - e0, 0);
    run_frame(16'h3D00, 8, 1'b0);
    repeat (2) @(negedge clk);
    chk("xchk_mismatch", xchk_cnt - e0, 1);
    exp_q = '{8'h3C, 8'h3D};
    drain("xchk_drain");
`else
    chk("xchk_tied_low", xchk_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
